lock_chamber_ctrl: RTL and testbench

//  Parametrised canal-lock chamber controller for the lab3 lock system. Moves a boat

---
 rtl/lock_chamber_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lock_chamber_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_chamber_ctrl.sv
// Canal-lock chamber controller: equalises chamber water to the source side, opens that gate,
// then equalises to the destination side and opens the other gate. Water updates on an internal tick.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | no transfer; waiting for req_in / req_out
// EQ_SRC   | moving chamber water toward the source-side level
// OPEN_SRC | source gate open, chamber follows source level
// EQ_DST   | moving chamber water toward the destination-side level
// OPEN_DST | destination gate open, chamber follows destination level
module lock_chamber_ctrl #(
    parameter int LEVEL_W    = 8,
    parameter int FILL_STEP  = 2,
    parameter int DRAIN_STEP = 3,
    parameter int TICK_DIV   = 4,
    parameter int INIT_LEVEL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] outer_level,
    input  logic [LEVEL_W-1:0] inner_level,
    input  logic               req_in,
    input  logic               req_out,
    input  logic               boat_clear,
    output logic               outer_gate,
    output logic               inner_gate,
    output logic               fill_valve,
    output logic               drain_valve,
    output logic [LEVEL_W-1:0] lock_level,
    output logic               busy,
    output logic [2:0]         state,
    output logic               tick
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EQ_SRC   = 3'd1,
        S_OPEN_SRC = 3'd2,
        S_EQ_DST   = 3'd3,
        S_OPEN_DST = 3'd4
    } state_t;

    localparam logic DIR_IN  = 1'b1;  // src = outer, dst = inner
    localparam logic DIR_OUT = 1'b0;  // src = inner, dst = outer

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W:0]   FILL_INC   = (LEVEL_W + 1)'(FILL_STEP);
    localparam logic [LEVEL_W:0]   DRAIN_DEC  = (LEVEL_W + 1)'(DRAIN_STEP);
    localparam logic [LEVEL_W-1:0] LEVEL_RST  = LEVEL_W'(INIT_LEVEL);

    state_t             state_q;
    state_t             state_nxt;
    logic               dir_q;
    logic               dir_nxt;
    logic               last_dir_q;
    logic               last_dir_nxt;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   tick_cnt_nxt;
    logic [LEVEL_W-1:0] lock_nxt;
    logic [LEVEL_W-1:0] tgt;
    logic [LEVEL_W-1:0] tgt_nxt;
    logic [LEVEL_W:0]   fill_sum;
    logic [LEVEL_W:0]   drain_diff;
    logic [LEVEL_W-1:0] filled;
    logic [LEVEL_W-1:0] drained;
    logic               eq_nxt;

    // Which side's live level the chamber is chasing in a given state/direction.
    function automatic logic [LEVEL_W-1:0] side_level(
        input state_t             s,
        input logic               d,
        input logic [LEVEL_W-1:0] outer,
        input logic [LEVEL_W-1:0] inner
    );
        logic src_phase;
        logic use_outer;
        src_phase = (s == S_EQ_SRC) || (s == S_OPEN_SRC);
        use_outer = src_phase ? (d == DIR_IN) : (d == DIR_OUT);
        return use_outer ? outer : inner;
    endfunction

    assign tgt          = side_level(state_q, dir_q, outer_level, inner_level);
    assign tick_cnt_nxt = (tick_cnt == CNT_MAX) ? '0 : tick_cnt + 1'b1;

    // One extra bit so the clamp sees overflow past the top and underflow below zero.
    assign fill_sum   = {1'b0, lock_level} + FILL_INC;
    assign drain_diff = {1'b0, lock_level} - DRAIN_DEC;
    assign filled     = (fill_sum > {1'b0, tgt}) ? tgt : fill_sum[LEVEL_W-1:0];
    assign drained    = (drain_diff[LEVEL_W] || (drain_diff[LEVEL_W-1:0] < tgt))
                        ? tgt : drain_diff[LEVEL_W-1:0];

    always_comb begin
        state_nxt    = state_q;
        dir_nxt      = dir_q;
        last_dir_nxt = last_dir_q;
        lock_nxt     = lock_level;
        case (state_q)
            S_IDLE: begin
                if (req_in || req_out) begin
                    state_nxt = S_EQ_SRC;
                    if (req_in && req_out) dir_nxt = ~last_dir_q;
                    else                   dir_nxt = req_in ? DIR_IN : DIR_OUT;
                end
            end
            S_EQ_SRC, S_EQ_DST: begin
                if (lock_level == tgt)
                    state_nxt = (state_q == S_EQ_SRC) ? S_OPEN_SRC : S_OPEN_DST;
                else if (tick)
                    lock_nxt = (lock_level < tgt) ? filled : drained;
            end
            S_OPEN_SRC: begin
                lock_nxt = tgt;
                if (boat_clear) state_nxt = S_EQ_DST;
            end
            S_OPEN_DST: begin
                lock_nxt = tgt;
                if (boat_clear) begin
                    state_nxt    = S_IDLE;
                    last_dir_nxt = dir_q;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign tgt_nxt = side_level(state_nxt, dir_nxt, outer_level, inner_level);
    assign eq_nxt  = (state_nxt == S_EQ_SRC) || (state_nxt == S_EQ_DST);

    // Every output is a flop loaded from next-state values, so inputs never reach outputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_OUT;
            last_dir_q  <= DIR_OUT;
            tick_cnt    <= '0;
            tick        <= 1'b0;
            lock_level  <= LEVEL_RST;
            outer_gate  <= 1'b0;
            inner_gate  <= 1'b0;
            fill_valve  <= 1'b0;
            drain_valve <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            dir_q       <= dir_nxt;
            last_dir_q  <= last_dir_nxt;
            tick_cnt    <= tick_cnt_nxt;
            tick        <= (tick_cnt_nxt == CNT_MAX);
            lock_level  <= lock_nxt;
            outer_gate  <= ((state_nxt == S_OPEN_SRC) && (dir_nxt == DIR_IN)) ||
                           ((state_nxt == S_OPEN_DST) && (dir_nxt == DIR_OUT));
            inner_gate  <= ((state_nxt == S_OPEN_SRC) && (dir_nxt == DIR_OUT)) ||
                           ((state_nxt == S_OPEN_DST) && (dir_nxt == DIR_IN));
            fill_valve  <= eq_nxt && (lock_nxt < tgt_nxt);
            drain_valve <= eq_nxt && (lock_nxt > tgt_nxt);
            busy        <= (state_nxt != S_IDLE);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl: directed lock transfers followed by random traffic,
// every cycle compared against a phase/level reference model.
module tb_lock_chamber_ctrl;

    localparam int LEVEL_W    = 8;
    localparam int FILL_STEP  = 2;
    localparam int DRAIN_STEP = 3;
    localparam int TICK_DIV   = 4;
    localparam int INIT_LEVEL = 0;

    logic               clk = 1'b0;
    logic               reset;
    logic [LEVEL_W-1:0] outer_level;
    logic [LEVEL_W-1:0] inner_level;
    logic               req_in;
    logic               req_out;
    logic               boat_clear;
    logic               outer_gate;
    logic               inner_gate;
    logic               fill_valve;
    logic               drain_valve;
    logic [LEVEL_W-1:0] lock_level;
    logic               busy;
    logic [2:0]         state;
    logic               tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0..4 (idle, eq src, open src, eq dst, open dst), dir 1 = inward.
    int m_ph;
    int m_lock;
    int m_cnt;
    bit m_dir;
    bit m_last;

    lock_chamber_ctrl #(
        .LEVEL_W(LEVEL_W), .FILL_STEP(FILL_STEP), .DRAIN_STEP(DRAIN_STEP),
        .TICK_DIV(TICK_DIV), .INIT_LEVEL(INIT_LEVEL)
    ) dut (
        .clk(clk), .reset(reset),
        .outer_level(outer_level), .inner_level(inner_level),
        .req_in(req_in), .req_out(req_out), .boat_clear(boat_clear),
        .outer_gate(outer_gate), .inner_gate(inner_gate),
        .fill_valve(fill_valve), .drain_valve(drain_valve),
        .lock_level(lock_level), .busy(busy), .state(state), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_tgt(input int ph, input bit dir);
        bit outer_side;
        outer_side = (ph == 1 || ph == 2) ? dir : !dir;
        return outer_side ? int'(outer_level) : int'(inner_level);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_lock = INIT_LEVEL;
        m_cnt  = 0;
        m_dir  = 0;
        m_last = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_gates"}, {outer_gate, inner_gate}, 0);
        check({tag, "_valves"}, {fill_valve, drain_valve}, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_level"}, lock_level, INIT_LEVEL);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit tick_now;
        int tgt;
        bit og;
        bit ig;
        @(posedge clk);
        tick_now = (m_cnt == TICK_DIV - 1);
        tgt = m_tgt(m_ph, m_dir);
        case (m_ph)
            0: if (req_in || req_out) begin
                m_dir = (req_in && req_out) ? !m_last : req_in;
                m_ph  = 1;
            end
            1, 3: begin
                if (m_lock == tgt) m_ph = m_ph + 1;
                else if (tick_now)
                    m_lock = (m_lock < tgt) ? min_i(m_lock + FILL_STEP, tgt)
                                            : max_i(m_lock - DRAIN_STEP, tgt);
            end
            2: begin
                m_lock = tgt;
                if (boat_clear) m_ph = 3;
            end
            default: begin
                m_lock = tgt;
                if (boat_clear) begin
                    m_ph   = 0;
                    m_last = m_dir;
                end
            end
        endcase
        m_cnt = (m_cnt + 1) % TICK_DIV;
        #1;
        og = (m_ph == 2 && m_dir) || (m_ph == 4 && !m_dir);
        ig = (m_ph == 2 && !m_dir) || (m_ph == 4 && m_dir);
        check("state", state, m_ph);
        check("busy", busy, m_ph != 0);
        check("lock_level", lock_level, m_lock);
        check("tick", tick, m_cnt == TICK_DIV - 1);
        check("gates", {outer_gate, inner_gate}, {og, ig});
        check("fill_valve", fill_valve, (m_ph == 1 || m_ph == 3) && m_lock < m_tgt(m_ph, m_dir));
        check("drain_valve", drain_valve, (m_ph == 1 || m_ph == 3) && m_lock > m_tgt(m_ph, m_dir));
        check("interlock", (outer_gate & inner_gate) | ((outer_gate | inner_gate) & (fill_valve | drain_valve)), 0);
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n = 0;
        while (m_ph != target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reached"}, state, target);
    endtask

    task automatic pulse_req(input bit rin, input bit rout);
        req_in  = rin;
        req_out = rout;
        step();
        req_in  = 0;
        req_out = 0;
    endtask

    task automatic pulse_clear();
        boat_clear = 1;
        step();
        boat_clear = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        reset       = 1;
        outer_level = 0;
        inner_level = 0;
        req_in      = 0;
        req_out     = 0;
        boat_clear  = 0;
        model_reset();
        apply_reset();

        // Full inward transfer: fill 0..10 then drain 10..0
        outer_level = 10;
        inner_level = 0;
        pulse_req(1, 0);
        check("t1_eq_src", state, 1);
        run_until("t1_open_src", 2, 200);
        check("t1_lvl_src", lock_level, 10);
        check("t1_outer_open", outer_gate, 1);
        pulse_clear();
        run_until("t1_open_dst", 4, 200);
        check("t1_lvl_dst", lock_level, 0);
        check("t1_inner_open", inner_gate, 1);
        pulse_clear();
        check("t1_idle", busy, 0);

        // Simultaneous requests alternate, inward first after reset
        apply_reset();
        outer_level = 6;
        inner_level = 3;
        pulse_req(1, 1);
        run_until("t2a_open_src", 2, 200);
        check("t2a_dir_in", {outer_gate, inner_gate}, 2'b10);
        pulse_clear();
        run_until("t2a_open_dst", 4, 200);
        pulse_clear();
        pulse_req(1, 1);
        run_until("t2b_open_src", 2, 200);
        check("t2b_dir_out", {outer_gate, inner_gate}, 2'b01);
        pulse_clear();
        run_until("t2b_open_dst", 4, 200);
        pulse_clear();

        // Saturation near the top and bottom of the level range
        outer_level = 254;
        inner_level = 255;
        pulse_req(1, 0);
        run_until("t3_open_254", 2, 1200);
        check("t3_lvl_254", lock_level, 254);
        pulse_clear();
        run_until("t3_open_255", 4, 100);
        check("t3_lvl_255", lock_level, 255);
        pulse_clear();
        inner_level = 1;
        outer_level = 0;
        pulse_req(0, 1);
        run_until("t3_open_1", 2, 1200);
        check("t3_lvl_1", lock_level, 1);
        pulse_clear();
        run_until("t3_open_0", 4, 100);
        check("t3_lvl_0", lock_level, 0);
        pulse_clear();

        // Already level: EQ_SRC for a single cycle, no valve activity
        pulse_req(1, 0);
        check("t4_eq_src", state, 1);
        check("t4_no_valve", {fill_valve, drain_valve}, 0);
        step();
        check("t4_open_src", state, 2);

        // Open water follows the source; requests from the far side are ignored
        outer_level = 10;
        step();
        outer_level = 12;
        step();
        check("t5_follow", lock_level, 12);
        pulse_req(0, 1);
        check("t5_inner_shut", inner_gate, 0);
        check("t5_still_open", state, 2);
        inner_level = 12;
        pulse_clear();
        run_until("t5_open_dst", 4, 100);
        pulse_clear();

        // Asynchronous reset in the middle of a fill
        outer_level = 200;
        pulse_req(1, 0);
        repeat (10) step();
        check("t6_filling", fill_valve, 1);
        #2 reset = 1;
        #1 check_reset_outputs("t6_async");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        pulse_req(1, 0);
        check("t6_restart", state, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) outer_level = LEVEL_W'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) inner_level = LEVEL_W'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) inner_level = outer_level;
            req_in     = ($urandom_range(0, 9) == 0);
            req_out    = ($urandom_range(0, 9) == 0);
            boat_clear = ($urandom_range(0, 5) == 0);
            step();
        end
        req_in     = 0;
        req_out    = 0;
        boat_clear = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
